// File: rtl/ssc_uart_pkg.sv
// Shared types and helpers for the SSC serial receiver.
// The baud divisor is rounded to the nearest integer.
package ssc_uart_pkg;

  localparam int BIT_COUNT = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/ssc_byte_fifo.sv
// First-word-fall-through byte buffer for the receiver.
// The head is presented combinationally, and the last popped word is held while the FIFO is empty.
module ssc_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                         clk_logic_i,
  input  logic                         system_reset_n,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         overrun_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] hold_q;
  logic             overrun_q;
  logic             empty, full, pop_ok, push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop_i && !empty;
  // A push into a full FIFO survives only when a pop frees a slot in the same cycle.
  assign push_ok = push_i && (!full || pop_ok);

  always_ff @(posedge clk_logic_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk_logic_i or negedge system_reset_n) begin
    if (!system_reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      hold_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push_i && full && !pop_ok;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        hold_q   <= mem_q[rd_ptr_q];
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o    = empty ? hold_q : mem_q[rd_ptr_q];
  assign valid_o   = !empty;
  assign count_o   = count_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/ssc_uart_rx.sv
// 8N1 receiver for the Super Serial Card link, with a buffered byte stream output.
// Handshake: a byte transfers on every rising edge where valid_o && ready_i; data_o is stable while valid_o && !ready_i.
module ssc_uart_rx
  import ssc_uart_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED_HZ = 54_000_000,
  parameter int unsigned BAUD_RATE      = 9600,
  parameter int unsigned OVERSAMPLE     = 16,
  parameter int unsigned FIFO_DEPTH     = 16
) (
  input  logic                              clk_logic_i,
  input  logic                              system_reset_n,
  input  logic                              uart_rx_i,
  output logic [7:0]                        data_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o,
  output logic                              framing_err_o,
  output logic                              overrun_o,
  output rx_state_t                         rx_state_o
);

  localparam int unsigned DIV = baud_div(CLOCK_SPEED_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);
  localparam logic [TW-1:0] MID_TICK = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

  logic       sync1_q, rx_s_q;
  rx_state_t  state_q, state_d;
  logic [PW-1:0] presc_q;
  logic [TW-1:0] tcnt_q;
  logic [2:0] bit_idx_q;
  logic [7:0] shift_q;
  logic       framing_q;

  logic tick, mid_start, mid_bit;
  logic cnt_clr, tcnt_clr, bit_clr, shift_en, push, frame_err;

  always_ff @(posedge clk_logic_i or negedge system_reset_n) begin
    if (!system_reset_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx_i;
      rx_s_q  <= sync1_q;
    end
  end

  assign tick      = (presc_q == DIV_LAST);
  // Tick number OVERSAMPLE/2 lands in the middle of the start bit; each later full period lands mid-bit.
  assign mid_start = tick && (tcnt_q == MID_TICK);
  assign mid_bit   = tick && (tcnt_q == LAST_TICK);

  always_ff @(posedge clk_logic_i or negedge system_reset_n) begin
    if (!system_reset_n) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    tcnt_clr  = 1'b0;
    bit_clr   = 1'b0;
    shift_en  = 1'b0;
    push      = 1'b0;
    frame_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        bit_clr = 1'b1;
        if (mid_start) begin
          if (!rx_s_q) begin
            state_d  = DATA;
            tcnt_clr = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (mid_bit) begin
          shift_en = 1'b1;
          if (bit_idx_q == 3'(BIT_COUNT - 1)) state_d = STOP;
        end
      end
      STOP: begin
        if (mid_bit) begin
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must not be mistaken for a new start bit.
        cnt_clr = 1'b1;
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_logic_i or negedge system_reset_n) begin
    if (!system_reset_n) begin
      presc_q   <= '0;
      tcnt_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      framing_q <= 1'b0;
    end else begin
      framing_q <= frame_err;
      if (cnt_clr) begin
        presc_q <= '0;
        tcnt_q  <= '0;
      end else begin
        presc_q <= tick ? '0 : presc_q + PW'(1);
        if (tcnt_clr)  tcnt_q <= '0;
        else if (tick) tcnt_q <= (tcnt_q == LAST_TICK) ? '0 : tcnt_q + TW'(1);
      end
      if (bit_clr)       bit_idx_q <= '0;
      else if (shift_en) bit_idx_q <= bit_idx_q + 3'd1;
      if (shift_en) shift_q <= {rx_s_q, shift_q[7:1]};
    end
  end

  ssc_byte_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk_logic_i    (clk_logic_i),
    .system_reset_n (system_reset_n),
    .push_i         (push),
    .push_data_i    (shift_q),
    .pop_i          (ready_i),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .count_o        (fifo_count_o),
    .overrun_o      (overrun_o)
  );

  assign framing_err_o = framing_q;
  assign rx_state_o    = state_q;

endmodule

// File: tb/tb_ssc_uart_rx.sv
// Bench for ssc_uart_rx at 1.536 MHz / 9600 baud (160 clocks per bit).
// A byte queue models the receive buffer; a monitor checks every handshake against it.
module tb_ssc_uart_rx;
  import ssc_uart_pkg::*;

  localparam int CLK_HZ   = 1_536_000;
  localparam int BAUD     = 9600;
  localparam int DEPTH    = 16;
  localparam int CW       = $clog2(DEPTH + 1);
  localparam int BIT_CLKS = CLK_HZ / BAUD;
  // 9.5 bit times to the stop-bit sample, plus 2 synchronizer clocks and 1 FSM clock.
  localparam int PUSH_LAT = 1523;

  logic          clk, rst_n, uart_rx, ready;
  logic [7:0]    data;
  logic          valid, framing_err, overrun;
  logic [CW-1:0] fifo_count;
  rx_state_t     rx_state;

  logic [7:0] exp_q[$];
  int checks, failures;
  int framing_seen, overrun_seen, exp_framing, exp_overrun;
  bit pop_at_push, rnd_done;
  logic [7:0] last_pop;
  int t1_lat, base_fr, base_ov;

  ssc_uart_rx #(
    .CLOCK_SPEED_HZ(CLK_HZ),
    .BAUD_RATE     (BAUD),
    .OVERSAMPLE    (16),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk_logic_i    (clk),
    .system_reset_n (rst_n),
    .uart_rx_i      (uart_rx),
    .data_o         (data),
    .valid_o        (valid),
    .ready_i        (ready),
    .fifo_count_o   (fifo_count),
    .framing_err_o  (framing_err),
    .overrun_o      (overrun),
    .rx_state_o     (rx_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic check_level(input string name);
    check(int'(fifo_count) == exp_q.size(), name, fifo_count, exp_q.size());
    check(valid == (exp_q.size() != 0), {name, "_valid"}, valid, exp_q.size() != 0);
  endtask

  task automatic hold_line(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame aligned to posedge+1; the model is updated as the stop bit begins.
  task automatic send_byte(input logic [7:0] b, input logic stop_val, input int stop_clks,
                           input bit count_it);
    @(posedge clk); #1;
    hold_line(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) hold_line(b[i], BIT_CLKS);
    if (!stop_val) exp_framing++;
    else if (count_it) begin
      if (exp_q.size() >= DEPTH && !pop_at_push) exp_overrun++;
      else exp_q.push_back(b);
    end
    hold_line(stop_val, stop_clks);
    uart_rx = 1'b1;
  endtask

  task automatic drain(input string name);
    ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      @(posedge clk); #1;
      if (!valid) break;
    end
    ready = 1'b0;
    check(!valid, {name, "_empty"}, valid, 0);
    check(exp_q.size() == 0, {name, "_model_empty"}, exp_q.size(), 0);
  endtask

  task automatic monitor_loop();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check(valid == (fifo_count != 0), "valid_vs_count", valid, fifo_count != 0);
        if (valid && ready) begin
          if (exp_q.size() == 0) check(0, "pop_unexpected", data, 0);
          else begin
            e = exp_q.pop_front();
            check(data == e, "pop_data", data, e);
            last_pop = e;
          end
        end
        if (framing_err) framing_seen++;
        if (overrun) overrun_seen++;
        if (framing_err || overrun)
          check(!(framing_err && overrun), "err_exclusive", {framing_err, overrun}, 0);
      end
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  initial begin
    uart_rx = 1'b1; ready = 1'b0; rst_n = 1'b0;
    fork
      monitor_loop();
      begin
        repeat (90_000) @(posedge clk);
        check(0, "watchdog", 0, 1);
        finish_run();
      end
    join_none

    repeat (3) @(posedge clk); #1;
    check(valid == 1'b0, "rst_valid", valid, 0);
    check(data == 8'h00, "rst_data", data, 0);
    check(fifo_count == 0, "rst_count", fifo_count, 0);
    check(framing_err == 1'b0, "rst_framing", framing_err, 0);
    check(overrun == 1'b0, "rst_overrun", overrun, 0);
    check(rx_state == IDLE, "rst_state", rx_state, IDLE);
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;

    // Test 1: first-byte latency.
    t1_lat = -1;
    fork
      send_byte(8'h55, 1'b1, BIT_CLKS, 1'b1);
      begin
        @(posedge clk);
        for (int n = 1; n <= 2000; n++) begin
          @(posedge clk); @(negedge clk);
          if (valid) begin t1_lat = n; break; end
        end
        check(t1_lat >= PUSH_LAT - 10 && t1_lat <= PUSH_LAT + 10, "t1_latency", t1_lat, PUSH_LAT);
        check(data == 8'h55, "t1_data", data, 8'h55);
        check(fifo_count == 1, "t1_count", fifo_count, 1);
      end
    join
    drain("t1");

    // Test 2: glitch rejection.
    base_fr = framing_seen;
    @(posedge clk); #1;
    hold_line(1'b0, 50);
    hold_line(1'b1, 400);
    check(rx_state == IDLE, "t2_state", rx_state, IDLE);
    check(fifo_count == 0, "t2_no_push", fifo_count, 0);
    send_byte(8'hA3, 1'b1, BIT_CLKS, 1'b1);
    check_level("t2_level");
    drain("t2");
    check(last_pop == 8'hA3, "t2_byte", last_pop, 8'hA3);
    check(framing_seen == base_fr, "t2_no_framing", framing_seen - base_fr, 0);

    // Test 3: framing error followed by a break.
    base_fr = framing_seen;
    send_byte(8'h0F, 1'b0, BIT_CLKS, 1'b1);
    hold_line(1'b0, 3 * BIT_CLKS / 2);
    check(rx_state == WAIT_HIGH, "t3_wait_high", rx_state, WAIT_HIGH);
    check(fifo_count == 0, "t3_no_push", fifo_count, 0);
    hold_line(1'b0, 3 * BIT_CLKS / 2);
    hold_line(1'b1, 200);
    check(framing_seen - base_fr == 1, "t3_framing", framing_seen - base_fr, 1);
    check(fifo_count == 0, "t3_still_empty", fifo_count, 0);
    send_byte(8'h3C, 1'b1, BIT_CLKS, 1'b1);
    check_level("t3_level");
    drain("t3");
    check(last_pop == 8'h3C, "t3_byte", last_pop, 8'h3C);

    // Test 4: overrun on the 17th byte.
    base_ov = overrun_seen;
    for (int i = 0; i <= DEPTH; i++) send_byte(8'(i), 1'b1, BIT_CLKS, 1'b1);
    check(fifo_count == 16, "t4_full", fifo_count, 16);
    check(overrun_seen - base_ov == 1, "t4_overrun", overrun_seen - base_ov, 1);
    check(exp_q.size() == 16 && exp_q[0] == 8'h00, "t4_model_head", exp_q[0], 8'h00);

    // Test 5: push and pop together while full (pops 8'h00, keeps 01..0F then EE).
    base_ov = overrun_seen;
    pop_at_push = 1'b1;
    fork
      send_byte(8'hEE, 1'b1, BIT_CLKS, 1'b1);
      begin
        @(posedge clk);
        repeat (PUSH_LAT - 1) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
      end
    join
    pop_at_push = 1'b0;
    check(fifo_count == 16, "t5_count", fifo_count, 16);
    check(overrun_seen == base_ov, "t5_no_overrun", overrun_seen - base_ov, 0);
    check(last_pop == 8'h00, "t5_first_pop", last_pop, 8'h00);
    drain("t45");
    check(last_pop == 8'hEE, "t5_last", last_pop, 8'hEE);
    check(data == 8'hEE, "t5_data_hold", data, 8'hEE);

    // Random traffic: random bytes, gaps, shortened stop bits and random ready.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send_byte(8'($urandom_range(0, 255)), 1'b1, $urandom_range(90, BIT_CLKS), 1'b1);
          repeat ($urandom_range(0, 30)) @(posedge clk);
          #1;
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1 ready = 1'($urandom_range(0, 1));
        end
        ready = 1'b0;
      end
    join
    drain("rnd");

    // Test 6: reset mid-frame with two bytes buffered.
    for (int i = 0; i < 2; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, BIT_CLKS, 1'b1);
    check_level("t6_level");
    fork
      send_byte(8'h81, 1'b1, BIT_CLKS, 1'b0);
      begin
        @(posedge clk);
        repeat (5 * BIT_CLKS + BIT_CLKS / 2) @(posedge clk);
        #3 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check(valid == 1'b0, "t6_valid", valid, 0);
        check(fifo_count == 0, "t6_count", fifo_count, 0);
        check(data == 8'h00, "t6_data", data, 0);
        check(rx_state == IDLE, "t6_state", rx_state, IDLE);
      end
    join
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) @(posedge clk); #1;
    send_byte(8'h81, 1'b1, BIT_CLKS, 1'b1);
    check_level("t6_after");
    check(data == 8'h81, "t6_byte", data, 8'h81);
    drain("t6");

    check(framing_seen == exp_framing, "total_framing", framing_seen, exp_framing);
    check(overrun_seen == exp_overrun, "total_overrun", overrun_seen, exp_overrun);
    finish_run();
  end

endmodule

// File: doc/ssc_uart_rx.md
Name: ssc_uart_rx

Overview:
Serial receiver for the far end of the Super Serial Card link. It deserializes the 8N1 stream that the card's 6551 drives on uart_tx_o. It buffers received bytes in a small FIFO and presents them on a valid/ready byte interface. Uses: loopback verification of the SSC, and an on-FPGA serial console/debug sink that sits beside the SSC on clk_logic.

Parameters:
CLOCK_SPEED_HZ, 54_000_000, frequency of clk_logic_i.
BAUD_RATE, 9600, line rate; matches the SSC default DIP setting.
OVERSAMPLE, 16, ticks per bit period.
FIFO_DEPTH, 16, receive buffer entries; must be a power of two, at least 2.

Ports:
clk_logic_i  input  1  system logic clock.
system_reset_n  input  1  asynchronous, active-low reset.
uart_rx_i  input  1  serial line, idle high, asynchronous to clk_logic_i.
data_o  output  8  head-of-FIFO byte; valid only while valid_o=1.
valid_o  output  1  FIFO not empty.
ready_i  input  1  consumer accepts data_o when valid_o&&ready_i.
fifo_count_o  output  $clog2(FIFO_DEPTH+1)  bytes currently held.
framing_err_o  output  1  one-cycle pulse when a stop bit is sampled low.
overrun_o  output  1  one-cycle pulse when a byte is dropped because the FIFO is full.

Behaviour:
- Reset (async assert, sync release) forces the following:
  - state=IDLE, FIFO empty, valid_o=0, data_o=8'h00, fifo_count_o=0, framing_err_o=0, overrun_o=0.
  - Both synchronizer flops =1.
  - Asserting reset mid-frame discards the partial byte and all buffered bytes.
- Input path: 2-flop synchronizer on uart_rx_i; all decisions use the synchronized value rx_s.
- Tick divisor:
  - DIV = (CLOCK_SPEED_HZ + BAUD_RATE*OVERSAMPLE/2) / (BAUD_RATE*OVERSAMPLE), rounded to nearest. For the defaults, DIV=352.
  - Prescaler counts 0..DIV-1 and emits a tick on wrap.
  - A tick counter counts 0..OVERSAMPLE-1.
  - Both counters are cleared on start detection and hold at 0 in IDLE.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on rx_s=0, clear counters and go to START.
  - START: at tick OVERSAMPLE/2 (mid start bit), if rx_s=0 go to DATA with bit index 0 and restart the tick count. Otherwise the low was a glitch; return to IDLE.
  - DATA: every OVERSAMPLE ticks (mid-bit), shift rx_s in LSB first. After bit index 7 is sampled, go to STOP.
  - STOP: at mid stop bit:
    - if rx_s=1, push the byte and go to IDLE;
    - if rx_s=0, pulse framing_err_o, discard the byte and go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. This covers break conditions: no restart occurs while the line is held low.
- No parity and exactly 1 stop bit are supported. The next start bit may begin immediately after the stop-bit sample point.
- FIFO (first-word-fall-through, sub-module):
  - Push is visible one clock after the stop-bit sample: valid_o=1 and data_o=byte on the following cycle.
  - Pop occurs on valid_o&&ready_i.
  - Push while full with no pop in the same cycle: byte dropped, overrun_o pulses, contents unchanged.
  - Push and pop in the same cycle while full: both occur, the count stays FIFO_DEPTH, no overrun.
  - Push and pop in the same cycle while empty: the push wins, count becomes 1 (the pop is ignored because valid_o=0).
  - Pointers wrap modulo FIFO_DEPTH.
  - data_o holds its last value when the FIFO is empty.
- framing_err_o and overrun_o cannot fire in the same cycle (the framing path never pushes).

Decomposition:
- ssc_uart_pkg holds:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, STOP, WAIT_HIGH};
  - function baud_div(clk_hz, baud, os) implementing the rounding rule;
  - localparam bit count 8.
- Sub-module ssc_byte_fifo: parameterized DEPTH/WIDTH synchronous FIFO with full/empty/count, on the same clock and reset.
- Top holds the synchronizer, prescaler and FSM. Target ~200 lines.

Test Plan:
All tests run with sim params CLOCK_SPEED_HZ=1_536_000, BAUD_RATE=9600 (DIV=10, 160 clk/bit).
1. Drive 8N1 byte 8'h55 -> valid_o rises with data_o=8'h55 and fifo_count_o=1 at 1520 +2 (sync) +1 clocks after the falling start edge, ±10 clocks.
2. Drive a 50-clock low pulse, then byte 8'hA3 after 400 idle clocks -> no push from the pulse; exactly one byte, 8'hA3, received; no framing_err_o.
3. Drive 8'h0F with stop bit 0 and hold the line low 3 more bit times, then idle, then send 8'h3C -> one framing_err_o pulse, no push during the low period, next byte 8'h3C received.
4. Hold ready_i=0 and send 17 bytes 8'h00..8'h10 -> fifo_count_o=16 and one overrun_o pulse on the 17th byte; raising ready_i drains 8'h00..8'h0F in order, then valid_o=0.
5. With the FIFO full, hold ready_i=1 exactly on the push cycle of a 17th byte 8'hEE -> no overrun_o, fifo_count_o stays 16, 8'hEE drained last.
6. Assert system_reset_n=0 during data bit 4 of 8'h81 (FIFO holding 2 bytes) -> valid_o=0 and fifo_count_o=0 asynchronously. After release, the next 8'h81 is received correctly.
